pc_trace_monitor: RTL and testbench

PC_TRACE_MONITOR -- requirements
Module: pc_trace_monitor

---
 rtl/pc_trace_monitor.sv | 186 ++++++++++++++++++
 tb/tb_pc_trace_monitor.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_trace_monitor.sv
// ============================================================================
// Module   : pc_trace_monitor
// Purpose  : Holds a CPU in reset and then runs it. While it runs, every PC is
//            stored in a circular trace buffer. The run halts on a cycle
//            limit, a PC stall or (optionally) a breakpoint, and the buffer
//            can then be read out oldest entry first.
// Options  : define PC_TRACE_BREAKPOINT_EN to add the bp_en/bp_addr breakpoint.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_trace_monitor #(
    parameter int PC_W         = 32,
    parameter int DEPTH        = 16,
    parameter int MAX_CYCLES   = 60,
    parameter int RST_CYCLES   = 1,
    parameter int STALL_CYCLES = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [PC_W-1:0]                    pc_in,
    input  logic                               rd_en,
`ifdef PC_TRACE_BREAKPOINT_EN
    input  logic                               bp_en,
    input  logic [PC_W-1:0]                    bp_addr,
`endif
    output logic                               cpu_rst,
    output logic                               running,
    output logic                               halted,
    output logic [1:0]                         halt_code,
    output logic [$clog2(MAX_CYCLES+1)-1:0]    cycle_cnt,
    output logic [$clog2(DEPTH+1)-1:0]         trace_cnt,
    output logic                               overflow,
    output logic [PC_W-1:0]                    rd_data,
    output logic                               rd_valid
);

    localparam int CW  = $clog2(MAX_CYCLES + 1);
    localparam int TW  = $clog2(DEPTH + 1);
    localparam int AW  = $clog2(DEPTH);
    localparam int RCW = $clog2(RST_CYCLES + 1);
    localparam int SW  = $clog2(STALL_CYCLES + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RESET = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    localparam logic [1:0] CODE_LIMIT = 2'b01;
    localparam logic [1:0] CODE_STALL = 2'b10;
    localparam logic [1:0] CODE_BP    = 2'b11;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [1:0]      code_nxt;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [RCW-1:0]  rst_cnt;
    logic [SW-1:0]   stall_run;
    logic [SW-1:0]   stall_run_nxt;
    logic            run_first;
    logic [PC_W-1:0] prev_pc;
    logic [PC_W-1:0] mem [DEPTH];

    logic            bp_hit;
    logic            stall_hit;
    logic            limit_hit;
    logic [CW-1:0]   cycle_cnt_nxt;

`ifdef PC_TRACE_BREAKPOINT_EN
    assign bp_hit = bp_en && (pc_in == bp_addr);
`else
    assign bp_hit = 1'b0;
`endif

    // Run length of identical samples; the first sample of a run counts as one.
    assign stall_run_nxt = (run_first || (pc_in != prev_pc)) ? SW'(1) : stall_run + SW'(1);
    assign stall_hit     = (stall_run_nxt == SW'(STALL_CYCLES));
    assign cycle_cnt_nxt = cycle_cnt + CW'(1);
    assign limit_hit     = (cycle_cnt_nxt == CW'(MAX_CYCLES));

    always_comb begin
        state_nxt = state;
        code_nxt  = 2'b00;
        case (state)
            IDLE: begin
                if (start) state_nxt = RESET;
            end
            RESET: begin
                if (rst_cnt == RCW'(RST_CYCLES - 1)) state_nxt = RUN;
            end
            RUN: begin
                if (bp_hit) begin
                    state_nxt = HALT;
                    code_nxt  = CODE_BP;
                end else if (stall_hit) begin
                    state_nxt = HALT;
                    code_nxt  = CODE_STALL;
                end else if (limit_hit) begin
                    state_nxt = HALT;
                    code_nxt  = CODE_LIMIT;
                end
            end
            HALT: begin
                if (start) state_nxt = RESET;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cpu_rst   <= 1'b1;
            running   <= 1'b0;
            halted    <= 1'b0;
            halt_code <= 2'b00;
            cycle_cnt <= '0;
            trace_cnt <= '0;
            overflow  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rst_cnt   <= '0;
            stall_run <= '0;
            run_first <= 1'b1;
            prev_pc   <= '0;
        end else begin
            // Status outputs follow the state being entered so they are registered.
            state    <= state_nxt;
            cpu_rst  <= (state_nxt != RUN);
            running  <= (state_nxt == RUN);
            halted   <= (state_nxt == HALT);
            rd_valid <= 1'b0;

            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        cycle_cnt <= '0;
                        trace_cnt <= '0;
                        overflow  <= 1'b0;
                        halt_code <= 2'b00;
                        wr_ptr    <= '0;
                        rd_ptr    <= '0;
                        rst_cnt   <= '0;
                        stall_run <= '0;
                        run_first <= 1'b1;
                    end else if ((state == HALT) && rd_en && (trace_cnt != '0)) begin
                        rd_data   <= mem[rd_ptr];
                        rd_valid  <= 1'b1;
                        rd_ptr    <= rd_ptr + AW'(1);
                        trace_cnt <= trace_cnt - TW'(1);
                    end
                end
                RESET: begin
                    rst_cnt <= rst_cnt + RCW'(1);
                end
                RUN: begin
                    wr_ptr    <= wr_ptr + AW'(1);
                    cycle_cnt <= cycle_cnt_nxt;
                    prev_pc   <= pc_in;
                    stall_run <= stall_run_nxt;
                    run_first <= 1'b0;
                    if (trace_cnt == TW'(DEPTH)) begin
                        rd_ptr   <= rd_ptr + AW'(1);
                        overflow <= 1'b1;
                    end else begin
                        trace_cnt <= trace_cnt + TW'(1);
                    end
                    if (state_nxt == HALT) halt_code <= code_nxt;
                end
                default: ;
            endcase
        end
    end

    // Trace storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && (state == RUN)) mem[wr_ptr] <= pc_in;
    end

endmodule

`default_nettype wire

// File: tb/tb_pc_trace_monitor.sv
// Testbench for pc_trace_monitor: a table of run scenarios checked against a
// reference trace queue, followed by hand-written reset and readout sequences.
`default_nettype none

module tb_pc_trace_monitor;
    localparam int PC_W   = 32;
    localparam int DEPTH  = 16;
    localparam int MAXC   = 60;
    localparam int RSTC   = 1;
    localparam int STALLC = 4;
    localparam int NEVER  = 1000;

    logic            clk = 1'b0;
    logic            rst, start, rd_en, bp_en;
    logic [PC_W-1:0] pc_in, bp_addr;
    logic            cpu_rst, running, halted, overflow, rd_valid;
    logic [1:0]      halt_code;
    logic [5:0]      cycle_cnt;
    logic [4:0]      trace_cnt;
    logic [PC_W-1:0] rd_data;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [PC_W-1:0] model[$];

    pc_trace_monitor #(
        .PC_W(PC_W), .DEPTH(DEPTH), .MAX_CYCLES(MAXC),
        .RST_CYCLES(RSTC), .STALL_CYCLES(STALLC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pc_in(pc_in), .rd_en(rd_en),
`ifdef PC_TRACE_BREAKPOINT_EN
        .bp_en(bp_en), .bp_addr(bp_addr),
`endif
        .cpu_rst(cpu_rst), .running(running), .halted(halted),
        .halt_code(halt_code), .cycle_cnt(cycle_cnt), .trace_cnt(trace_cnt),
        .overflow(overflow), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hold_at;  // pc = 4*min(k, hold_at) for the k-th RUN sample
        int bp_at;    // bp_en asserted from sample bp_at on
        int bp_pc;
        int code;
        int cycles;
        int trace;
        int ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [PC_W-1:0] act, input logic [PC_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_start();
        int n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("enter_reset_cpu_rst", cpu_rst, 1);
        chk("enter_reset_running", running, 0);
        chk("enter_reset_trace_cnt", trace_cnt, 0);
        chk("enter_reset_cycle_cnt", cycle_cnt, 0);
        chk("enter_reset_halt_code", halt_code, 0);
        n = 0;
        while (!running && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reset_length", n, RSTC);
    endtask

    task automatic obs_pop(inout int pulses);
        if (rd_valid) begin
            pulses++;
            if (model.size() == 0) chk("pop_unexpected", 1, 0);
            else chk("pop_data", rd_data, model.pop_front());
        end
    endtask

    task automatic readout(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            obs_pop(pulses);
            @(negedge clk);
            obs_pop(pulses);
        end
    endtask

    task automatic run_to_halt(input vec_t v);
        int k;
        logic [PC_W-1:0] pc;
        model.delete();
        bp_addr = v.bp_pc;
        bp_en   = 1'b0;
        do_start();
        k = 0;
        while (running && k < 200) begin
            pc    = 4 * ((k < v.hold_at) ? k : v.hold_at);
            pc_in = pc;
            bp_en = (k >= v.bp_at);
            model.push_back(pc);
            if (model.size() > DEPTH) void'(model.pop_front());
            k++;
            @(negedge clk);
        end
        bp_en = 1'b0;
        if (k >= 200) chk("run_timeout", 1, 0);
        chk("halted", halted, 1);
        chk("halt_cpu_rst", cpu_rst, 1);
        chk("halt_code", halt_code, v.code);
        chk("cycle_cnt", cycle_cnt, v.cycles);
        chk("trace_cnt", trace_cnt, v.trace);
        chk("overflow", overflow, v.ovf);
    endtask

    initial begin
        int pulses;
        rst = 1'b1; start = 1'b0; rd_en = 1'b0; bp_en = 1'b0;
        pc_in = '0; bp_addr = '0;

        //                 hold   bp_at  bp_pc  code cyc trace ovf
        vecs.push_back('{NEVER, NEVER, 0,     1,   60, 16,   1});
        vecs.push_back('{2,     NEVER, 0,     2,   6,  6,    0});
        vecs.push_back('{0,     NEVER, 0,     2,   4,  4,    0});
        vecs.push_back('{12,    NEVER, 0,     2,   16, 16,   0});
        vecs.push_back('{13,    NEVER, 0,     2,   17, 16,   1});
        vecs.push_back('{20,    NEVER, 0,     2,   24, 16,   1});
        vecs.push_back('{57,    NEVER, 0,     1,   60, 16,   1});
        vecs.push_back('{56,    NEVER, 0,     2,   60, 16,   1});
`ifdef PC_TRACE_BREAKPOINT_EN
        vecs.push_back('{NEVER, 0,     'h14,  3,   6,  6,    0});
        vecs.push_back('{2,     5,     'h8,   3,   6,  6,    0});
`endif

        @(negedge clk);
        @(negedge clk);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_running", running, 0);
        chk("rst_halted", halted, 0);
        chk("rst_trace_cnt", trace_cnt, 0);
        chk("rst_rd_valid", rd_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_to_halt(vecs[i]);
            readout(vecs[i].trace + 2, pulses);
            chk("pop_pulses", pulses, vecs[i].trace);
            chk("drained_trace_cnt", trace_cnt, 0);
        end

        // Partial drain leaves 3 entries; 5 requests must yield exactly 3 pops.
        run_to_halt(vecs[1]);
        readout(3, pulses);
        chk("partial_pulses", pulses, 3);
        chk("partial_trace_cnt", trace_cnt, 3);
        readout(5, pulses);
        chk("five_req_pulses", pulses, 3);

        // start together with rd_en in HALT: restart wins, no pop.
        run_to_halt(vecs[1]);
        start = 1'b1;
        rd_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rd_en = 1'b0;
        chk("start_wins_rd_valid", rd_valid, 0);
        chk("start_wins_trace_cnt", trace_cnt, 0);
        chk("start_wins_cpu_rst", cpu_rst, 1);
        chk("start_wins_halted", halted, 0);

        // Into RUN; start mid-run is ignored, then rst on RUN cycle 10.
        begin
            int n;
            n = 0;
            while (!running && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("rerun_running", running, 1);
        end
        for (int k = 0; k < 10; k++) begin
            pc_in = 32'h100 + 4 * k;
            start = (k == 4);
            @(negedge clk);
        end
        start = 1'b0;
        chk("start_in_run_running", running, 1);
        chk("start_in_run_cycle_cnt", cycle_cnt, 10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_rst_cpu_rst", cpu_rst, 1);
        chk("midrun_rst_running", running, 0);
        chk("midrun_rst_halted", halted, 0);
        chk("midrun_rst_halt_code", halt_code, 0);
        chk("midrun_rst_cycle_cnt", cycle_cnt, 0);
        chk("midrun_rst_trace_cnt", trace_cnt, 0);
        chk("midrun_rst_overflow", overflow, 0);
        chk("midrun_rst_rd_valid", rd_valid, 0);
        chk("midrun_rst_rd_data", rd_data, 0);
        model.delete();
        readout(3, pulses);
        chk("idle_rd_pulses", pulses, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
